mux16_rr_sched: RTL and testbench
=================================

MUX16_RR_SCHED -- requirements
Module: mux16_rr_sched

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 8, giving the maximum number of consecutive grant cycles per owner; legal range is 1..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port req, input, 16 bits: request from source n on bit n, where source n drives 16:1 mux data input n.
REQ-005 SHALL have port done, input, 1 bit: the current owner releases the mux at the end of this cycle.
REQ-006 SHALL have port sel, output, 4 bits: the mux select, registered.
REQ-007 SHALL have port gnt, output, 16 bits: one-hot grant, registered, with gnt[sel]=1 while busy.
REQ-008 SHALL have port busy, output, 1 bit: a grant is active, so the mux output is valid for the owner.

Function
REQ-009 SHALL implement two states: IDLE and GRANT.
REQ-010 SHALL keep an internal 4-bit round-robin pointer ptr and an 8-bit hold counter hcnt.
REQ-011 In IDLE with req!=0 at a clock edge, SHALL select the first set req bit searching ptr, ptr+1, ... 15, 0, ... ptr-1 (modulo 16).
- In the same edge it loads sel with that index, sets gnt to that one-hot value, sets busy=1, clears hcnt, and enters GRANT.
REQ-012 In IDLE with req==0, SHALL hold state, keep gnt=0 and busy=0, and keep sel at its last value so the mux input stays stable.
REQ-013 Latency: a request first sampled at edge k SHALL produce gnt/busy visible after edge k, i.e. one clock from request to grant.
REQ-014 In GRANT, SHALL release at an edge where done=1 OR req[sel]=0 (or on a timeout per REQ-022).
- On release: gnt=0, busy=0, ptr=sel+1 modulo 16 (15 wraps to 0), and the block returns to IDLE.
REQ-015 SHALL insert exactly one IDLE cycle (busy=0) between any two grants, including back-to-back grants to different sources.
REQ-016 While in GRANT, SHALL ignore req bits other than req[sel]; sel and gnt SHALL NOT change during a grant.
REQ-017 SHALL treat done=1 together with req[sel]=0 in the same cycle as a single release with identical behaviour.
REQ-018 SHALL ignore done while in IDLE.
REQ-019 SHALL increment hcnt on every GRANT cycle without release, saturating at 255.
REQ-020 SHALL guarantee gnt is zero or one-hot at all times, and that gnt!=0 if and only if busy=1.

Reset
REQ-021 When rst_n=0 at an edge, SHALL set state=IDLE, ptr=0, hcnt=0, sel=0, gnt=0 and busy=0.
- Reset asserted mid-grant drops the grant at that edge.
- Reset overrides done and req.
- The first grant after reset searches from source 0.

Configuration
REQ-022 With macro MUX16_SCHED_TIMEOUT_EN defined, SHALL force a release at the edge where the owner has been granted for HOLD_MAX cycles, even if req[sel]=1 and done=0.
- The release behaves exactly as in REQ-014, with ptr advanced to sel+1.
- A still-requesting source re-competes in round-robin order.
REQ-023 Without MUX16_SCHED_TIMEOUT_EN, a grant SHALL last until done or request drop with no upper bound, and HOLD_MAX has no effect.

Verification
REQ-024 Single request: reset, then req=16'h0001 for 4 cycles, then 0.
- Expected: sel=0, gnt=16'h0001 and busy=1 one cycle after req; busy=0 the cycle after req drops; ptr=1.
REQ-025 Round-robin fairness: req=16'hFFFF held, done pulsed on each grant's second cycle.
- Expected: grant order 0, 1, 2 ... 15, 0 with exactly one idle cycle between grants.
REQ-026 Wrap and skip: ptr=14 after granting 13, req=16'h0009.
- Expected: next grant sel=0 (search wraps from 14 through 15 to 0), then sel=3.
REQ-027 Simultaneous release: done=1 and req[sel]=0 in the same cycle while sel=5.
- Expected: exactly one release, next ptr=6, no spurious grant to 5.
REQ-028 Reset mid-grant: rst_n=0 for one cycle during a grant to sel=9 with req=16'h0200 held.
- Expected: gnt=0, sel=0 after the reset edge, then re-grant to 9 on the next edge.
REQ-029 Timeout, with MUX16_SCHED_TIMEOUT_EN and HOLD_MAX=4: req=16'h0003 held, done=0.
- Expected: source 0 busy for 4 cycles, 1 idle cycle, source 1 for 4 cycles, repeating.
- Without the macro: source 0 is held indefinitely.

Source files
------------

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler driving the select of a 16:1 mux, with one idle cycle between owners.
// Optional per-owner hold limit: define MUX16_SCHED_TIMEOUT_EN to release an owner after HOLD_MAX grant cycles.
module mux16_rr_sched #(
  parameter int HOLD_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        done,
  output logic [3:0]  sel,
  output logic [15:0] gnt,
  output logic        busy,
  output logic        dbg_state_o,
  output logic [3:0]  dbg_ptr_o,
  output logic [7:0]  dbg_hcnt_o
);

  // Handshake: source n raises req[n] and keeps it high while it wants the mux;
  // it owns the mux while gnt[n]=1 (busy=1, sel=n) and gives it back by pulsing
  // done or dropping req[n]. The grant lands one edge after the request is seen.

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("HOLD_MAX must be in 1..255");
  end

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t      state_q;
  logic [3:0]  ptr_q;
  logic [7:0]  hcnt_q;
  logic [7:0]  hcnt_d;
  logic [3:0]  sel_q;
  logic [15:0] gnt_q;
  logic        busy_q;

  logic        pick_vld;
  logic [3:0]  pick_idx;
  logic        timeout;
  logic        release_now;

  // Scan from the farthest offset down so the nearest request to ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = ptr_q;
    for (int i = 15; i >= 0; i--) begin
      if (req[ptr_q + 4'(i)]) begin
        pick_vld = 1'b1;
        pick_idx = ptr_q + 4'(i);
      end
    end
  end

`ifdef MUX16_SCHED_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  // hcnt counts up by one from zero, so equality is reached exactly on the last allowed cycle.
  assign timeout = (hcnt_q == HOLD_LAST);
`else
  assign timeout = 1'b0;
`endif

  assign release_now = done || !req[sel_q] || timeout;
  assign hcnt_d      = (hcnt_q == 8'hFF) ? hcnt_q : hcnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 4'd0;
      hcnt_q  <= 8'd0;
      sel_q   <= 4'd0;
      gnt_q   <= 16'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            state_q <= ST_GRANT;
            sel_q   <= pick_idx;
            gnt_q   <= 16'd1 << pick_idx;
            busy_q  <= 1'b1;
            hcnt_q  <= 8'd0;
          end
        end
        ST_GRANT: begin
          if (release_now) begin
            state_q <= ST_IDLE;
            gnt_q   <= 16'd0;
            busy_q  <= 1'b0;
            ptr_q   <= sel_q + 4'd1;
          end else begin
            hcnt_q  <= hcnt_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= 16'd0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sel         = sel_q;
  assign gnt         = gnt_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;
  assign dbg_hcnt_o  = hcnt_q;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Directed bench for mux16_rr_sched: a vector table for single-step behaviour plus
// hand sequences for round-robin order and long holds (timeout when MUX16_SCHED_TIMEOUT_EN is set).
module tb_mux16_rr_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic        done;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        busy;
  logic        dbg_state;
  logic [3:0]  dbg_ptr;
  logic [7:0]  dbg_hcnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  mux16_rr_sched #(.HOLD_MAX(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .sel         (sel),
    .gnt         (gnt),
    .busy        (busy),
    .dbg_state_o (dbg_state),
    .dbg_ptr_o   (dbg_ptr),
    .dbg_hcnt_o  (dbg_hcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [15:0] req;
    logic        done;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        busy;
    logic [3:0]  ptr;
  } vec_t;

  localparam int NV = 28;
  vec_t vec [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [15:0] q, input logic d);
    rst_n = r;
    req   = q;
    done  = d;
    @(posedge clk);
    #1;
  endtask

  // Grant must be zero or one-hot, and nonzero exactly when busy.
  always @(negedge clk) begin
    if (mon_en) begin
      n_tests++;
      if (!$onehot0(gnt) || ((gnt != 16'd0) !== busy)) begin
        n_fail++;
        $display("FAIL gnt_invariant: gnt=%0h busy=%0b, expected one-hot gnt tracking busy", gnt, busy);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 16'd0;
    done  = 1'b0;

    //           rst   req       done  sel    gnt       busy  ptr
    vec[0]  = '{1'b0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0};
    vec[1]  = '{1'b0, 16'hFFFF, 1'b1, 4'd0,  16'h0000, 1'b0, 4'd0};
    vec[2]  = '{1'b1, 16'h0001, 1'b0, 4'd0,  16'h0001, 1'b1, 4'd0};
    vec[3]  = '{1'b1, 16'h0001, 1'b0, 4'd0,  16'h0001, 1'b1, 4'd0};
    vec[4]  = '{1'b1, 16'h0001, 1'b0, 4'd0,  16'h0001, 1'b1, 4'd0};
    vec[5]  = '{1'b1, 16'h0001, 1'b0, 4'd0,  16'h0001, 1'b1, 4'd0};
    vec[6]  = '{1'b1, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd1};
    vec[7]  = '{1'b1, 16'h0000, 1'b1, 4'd0,  16'h0000, 1'b0, 4'd1};
    vec[8]  = '{1'b1, 16'h0003, 1'b0, 4'd1,  16'h0002, 1'b1, 4'd1};
    vec[9]  = '{1'b1, 16'h0003, 1'b1, 4'd1,  16'h0000, 1'b0, 4'd2};
    vec[10] = '{1'b1, 16'h0003, 1'b0, 4'd0,  16'h0001, 1'b1, 4'd2};
    vec[11] = '{1'b1, 16'hFFFF, 1'b0, 4'd0,  16'h0001, 1'b1, 4'd2};
    vec[12] = '{1'b1, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd1};
    vec[13] = '{1'b1, 16'h2000, 1'b0, 4'd13, 16'h2000, 1'b1, 4'd1};
    vec[14] = '{1'b1, 16'h2000, 1'b1, 4'd13, 16'h0000, 1'b0, 4'd14};
    vec[15] = '{1'b1, 16'h0009, 1'b0, 4'd0,  16'h0001, 1'b1, 4'd14};
    vec[16] = '{1'b1, 16'h0009, 1'b1, 4'd0,  16'h0000, 1'b0, 4'd1};
    vec[17] = '{1'b1, 16'h0009, 1'b0, 4'd3,  16'h0008, 1'b1, 4'd1};
    vec[18] = '{1'b1, 16'h0000, 1'b0, 4'd3,  16'h0000, 1'b0, 4'd4};
    vec[19] = '{1'b1, 16'h0020, 1'b0, 4'd5,  16'h0020, 1'b1, 4'd4};
    vec[20] = '{1'b1, 16'h0000, 1'b1, 4'd5,  16'h0000, 1'b0, 4'd6};
    vec[21] = '{1'b1, 16'h0060, 1'b0, 4'd6,  16'h0040, 1'b1, 4'd6};
    vec[22] = '{1'b1, 16'h0000, 1'b0, 4'd6,  16'h0000, 1'b0, 4'd7};
    vec[23] = '{1'b1, 16'h0200, 1'b0, 4'd9,  16'h0200, 1'b1, 4'd7};
    vec[24] = '{1'b1, 16'h0200, 1'b0, 4'd9,  16'h0200, 1'b1, 4'd7};
    vec[25] = '{1'b0, 16'h0200, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0};
    vec[26] = '{1'b1, 16'h0200, 1'b0, 4'd9,  16'h0200, 1'b1, 4'd0};
    vec[27] = '{1'b1, 16'h0000, 1'b0, 4'd9,  16'h0000, 1'b0, 4'd10};

    for (int i = 0; i < NV; i++) begin
      step(vec[i].rst_n, vec[i].req, vec[i].done);
      mon_en = 1'b1;
      check($sformatf("vec%0d_sel", i),  32'(sel),     32'(vec[i].sel));
      check($sformatf("vec%0d_gnt", i),  32'(gnt),     32'(vec[i].gnt));
      check($sformatf("vec%0d_busy", i), 32'(busy),    32'(vec[i].busy));
      check($sformatf("vec%0d_ptr", i),  32'(dbg_ptr), 32'(vec[i].ptr));
    end

    // All sources requesting, done on each grant's second cycle: order 0..15 then 0.
    step(1'b0, 16'h0000, 1'b0);
    for (int k = 0; k < 17; k++) begin
      logic [3:0] exp_sel;
      exp_sel = 4'(k);
      step(1'b1, 16'hFFFF, 1'b0);
      check($sformatf("rr%0d_grant_sel", k),  32'(sel),  32'(exp_sel));
      check($sformatf("rr%0d_grant_gnt", k),  32'(gnt),  32'(16'd1 << exp_sel));
      check($sformatf("rr%0d_grant_busy", k), 32'(busy), 32'd1);
      step(1'b1, 16'hFFFF, 1'b0);
      check($sformatf("rr%0d_hold_sel", k),   32'(sel),  32'(exp_sel));
      check($sformatf("rr%0d_hold_busy", k),  32'(busy), 32'd1);
      step(1'b1, 16'hFFFF, 1'b1);
      check($sformatf("rr%0d_idle_busy", k),  32'(busy), 32'd0);
      check($sformatf("rr%0d_idle_sel", k),   32'(sel),  32'(exp_sel));
    end

    // req=0003 held with done=0 from a fresh reset.
    step(1'b0, 16'h0000, 1'b0);
`ifdef MUX16_SCHED_TIMEOUT_EN
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 5; c++) begin
        step(1'b1, 16'h0003, 1'b0);
        if (c < 4) begin
          check($sformatf("to_p%0d_c%0d_busy", p, c), 32'(busy), 32'd1);
          check($sformatf("to_p%0d_c%0d_sel", p, c),  32'(sel),  32'(p % 2));
        end else begin
          check($sformatf("to_p%0d_idle_busy", p), 32'(busy), 32'd0);
        end
      end
    end
`else
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 16'h0003, 1'b0);
      check($sformatf("hold_c%0d_busy", c), 32'(busy), 32'd1);
      check($sformatf("hold_c%0d_sel", c),  32'(sel),  32'd0);
    end
    check("hold_hcnt", 32'(dbg_hcnt), 32'd19);
`endif

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
